hex_display_scanner: RTL and testbench

Time-multiplexed scanner for a multi-digit common-anode seven-segment display. It holds a DIGITS-nibble display value and cycles through the digits at a programmable rate. For each digit it drives one active-low digit enable and presents that digit's nibble, inverted, on IN_1/IN_2/IN_4/IN_8. Those outputs connect directly to the inverted-logic inputs of hex2sevenseg. New values are double-buffered and committed only at frame boundaries, so the display never shows a partial update.

---
 rtl/hex_display_scanner.sv | 124 ++++++++++++
 tb/tb_hex_display_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Purpose: time-multiplexed scanner for a common-anode seven-segment display, double-buffered value.
// Latency: outputs are registered, one cycle behind the scan counters; LOAD->PENDING is 1 cycle.
// Backpressure: none; LOAD is always accepted and the last LOAD before a frame boundary wins.
//
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   VALUE[4*DIGITS-1:0]  new display value, digit 0 in VALUE[3:0] (rightmost)
//   LOAD                 one-cycle strobe capturing VALUE into the shadow register
//   BLANK_LZ             1 = suppress leading zeros
//   IN_1/IN_2/IN_4/IN_8  inverted nibble of the current digit, for an inverted-input decoder
//   DIG_N[DIGITS-1:0]    active-low one-hot digit enable, all ones = display off
//   PENDING              shadow value waiting for the next frame boundary
//   FRAME                one-cycle pulse in the first output cycle of each frame
module hex_display_scanner #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_GAP = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LOAD,
  input  logic                  BLANK_LZ,
  output logic                  IN_1,
  output logic                  IN_2,
  output logic                  IN_4,
  output logic                  IN_8,
  output logic [DIGITS-1:0]     DIG_N,
  output logic                  PENDING,
  output logic                  FRAME
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

  logic [PW-1:0]         r_p;
  logic [DW-1:0]         r_d;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_display;
  logic                  r_pending;
  logic                  r_wrap_d;
  logic                  r_frame;
  logic [DIGITS-1:0]     r_dig_n;
  logic [3:0]            r_in;

  logic                  w_p_last;
  logic                  w_wrap;
  logic                  w_lit;
  logic [DW-1:0]         w_h;
  logic                  w_vis;
  logic [3:0]            w_nib;
  logic [DIGITS-1:0]     w_dig_n;

  assign w_p_last = (r_p == P_LAST);
  assign w_wrap   = w_p_last && (r_d == D_LAST);

  // Anti-ghosting: the first BLANK_GAP cycles of each slot keep every digit off.
  generate
    if (BLANK_GAP == 0) begin : g_no_gap
      assign w_lit = 1'b1;
    end else begin : g_gap
      localparam logic [PW-1:0] GAP = PW'(BLANK_GAP);
      assign w_lit = (r_p >= GAP);
    end
  endgenerate

  // Index of the highest nonzero digit; stays 0 for an all-zero value so digit 0 is always visible.
  always_comb begin
    w_h = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_display[4*i +: 4] != 4'h0) w_h = DW'(i);
    end
  end

  assign w_vis = !BLANK_LZ || (r_d <= w_h);
  assign w_nib = r_display[{r_d, 2'b00} +: 4];

  always_comb begin
    w_dig_n = '1;
    if (w_lit && w_vis) w_dig_n[r_d] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_p       <= '0;
      r_d       <= '0;
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
      r_wrap_d  <= 1'b0;
      r_frame   <= 1'b0;
      r_dig_n   <= '1;
      r_in      <= 4'hF;
    end else begin
      r_p <= w_p_last ? '0 : r_p + 1'b1;
      if (w_p_last) r_d <= (r_d == D_LAST) ? '0 : r_d + 1'b1;

      // Commit uses the shadow as it was before this edge, so a LOAD on the
      // wrap cycle lands in the shadow and waits for the following frame.
      if (w_wrap && r_pending) r_display <= r_shadow;
      if (LOAD) r_shadow <= VALUE;
      r_pending <= LOAD || (r_pending && !w_wrap);

      // The wrap is seen by the counters one edge before the outputs show
      // digit 0, so FRAME is delayed by two stages to line up with them.
      r_wrap_d <= w_wrap;
      r_frame  <= r_wrap_d;

      r_dig_n <= w_dig_n;
      r_in    <= ~w_nib;
    end
  end

  assign DIG_N   = r_dig_n;
  assign IN_1    = r_in[0];
  assign IN_2    = r_in[1];
  assign IN_4    = r_in[2];
  assign IN_8    = r_in[3];
  assign PENDING = r_pending;
  assign FRAME   = r_frame;

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

  logic        CLK;
  logic        RST_N;
  logic [15:0] VALUE;
  logic        LOAD;
  logic        BLANK_LZ;
  logic        IN_1, IN_2, IN_4, IN_8;
  logic [3:0]  DIG_N;
  logic        PENDING;
  logic        FRAME;

  hex_display_scanner #(.DIGITS(4), .PRESCALE(8), .BLANK_GAP(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .LOAD(LOAD), .BLANK_LZ(BLANK_LZ),
    .IN_1(IN_1), .IN_2(IN_2), .IN_4(IN_4), .IN_8(IN_8),
    .DIG_N(DIG_N), .PENDING(PENDING), .FRAME(FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int K_DIGN = 0;
  localparam int K_IN   = 1;
  localparam int K_PEND = 2;
  localparam int K_FRM  = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t sb_keep[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt;

  // Edges counted from 1 after reset release.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic string kname(int k);
    case (k)
      K_DIGN:  return "dig_n";
      K_IN:    return "in";
      K_PEND:  return "pending";
      default: return "frame";
    endcase
  endfunction

  function automatic logic [3:0] actual(int k);
    case (k)
      K_DIGN:  return DIG_N;
      K_IN:    return {IN_8, IN_4, IN_2, IN_1};
      K_PEND:  return {3'b000, PENDING};
      default: return {3'b000, FRAME};
    endcase
  endfunction

  // Monitor: every output cycle, compare all expectations due now; stale ones count as missed.
  always @(negedge CLK) begin
    if (RST_N) begin
      sb_keep = {};
      foreach (sb[i]) begin
        if (sb[i].cyc == edge_cnt) begin
          checks++;
          if (actual(sb[i].kind) !== sb[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", kname(sb[i].kind), edge_cnt,
                     actual(sb[i].kind), sb[i].val);
          end
        end else if (sb[i].cyc < edge_cnt) begin
          checks++;
          errors++;
          $display("FAIL missed_%s cyc=%0d now=%0d", kname(sb[i].kind), sb[i].cyc, edge_cnt);
        end else begin
          sb_keep.push_back(sb[i]);
        end
      end
      sb = sb_keep;
    end
  end

  task automatic expect_at(int cyc, int kind, logic [3:0] v);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = v;
    sb.push_back(e);
  endtask

  // One frame of cadence: in16 holds the expected IN nibble per digit, en which digits light.
  task automatic expect_frame(int start, int cnt, logic [15:0] in16, logic [3:0] en);
    for (int k = 0; k < cnt; k++) begin
      int         p, slot;
      logic [3:0] dn;
      p    = k % 8;
      slot = k / 8;
      dn   = 4'hF;
      if (p >= 2 && en[slot]) dn[slot] = 1'b0;
      expect_at(start + k, K_DIGN, dn);
      expect_at(start + k, K_IN, in16[slot*4 +: 4]);
    end
  endtask

  task automatic check_now(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Returns at the falling edge following rising edge n.
  task automatic goto(int n);
    int guard = 0;
    while (edge_cnt < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (edge_cnt != n) begin
      checks++;
      errors++;
      $display("FAIL goto actual=%0d required=%0d", edge_cnt, n);
    end
  endtask

  // LOAD is sampled by rising edge n.
  task automatic load(int n, logic [15:0] v);
    goto(n - 1);
    LOAD  = 1'b1;
    VALUE = v;
    goto(n);
    LOAD  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout edge=%0d", edge_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    RST_N    = 1'b0;
    LOAD     = 1'b0;
    VALUE    = 16'h0;
    BLANK_LZ = 1'b0;
    #12;
    check_now("reset_dig_n", DIG_N, 4'hF);
    check_now("reset_in", {IN_8, IN_4, IN_2, IN_1}, 4'hF);
    check_now("reset_pending", {3'b0, PENDING}, 4'h0);
    check_now("reset_frame", {3'b0, FRAME}, 4'h0);

    // Scenario 1: cadence from reset, blank (zero) display.
    expect_frame(1, 32, 16'hFFFF, 4'b1111);
    expect_frame(33, 32, 16'hFFFF, 4'b1111);
    expect_at(1, K_PEND, 4'h0);
    expect_at(1, K_FRM, 4'h0);
    expect_at(32, K_FRM, 4'h0);
    for (int k = 1; k <= 9; k++) begin
      expect_at(32*k + 1, K_FRM, 4'h1);
      expect_at(32*k + 2, K_FRM, 4'h0);
    end
    @(negedge CLK);
    RST_N = 1'b1;

    // Scenario 2: load mid-frame, commit at wrap.
    expect_at(40, K_PEND, 4'h1);
    expect_at(63, K_PEND, 4'h1);
    expect_at(64, K_PEND, 4'h0);
    expect_frame(65, 32, 16'hEDCB, 4'b1111);
    load(40, 16'h1234);

    // Scenario 3: leading-zero blanking.
    expect_frame(97, 32, 16'hFFAF, 4'b0011);
    expect_frame(129, 32, 16'hFFFF, 4'b0001);
    expect_frame(161, 32, 16'hFFFF, 4'b1111);
    expect_at(70, K_PEND, 4'h1);
    expect_at(96, K_PEND, 4'h0);
    expect_at(128, K_PEND, 4'h0);
    goto(69);
    BLANK_LZ = 1'b1;
    load(70, 16'h0050);
    load(100, 16'h0000);
    goto(160);
    BLANK_LZ = 1'b0;

    // Scenario 4: overwrite before commit, and load on the wrap cycle.
    expect_frame(193, 32, 16'h5555, 4'b1111);
    expect_frame(225, 32, 16'h5555, 4'b1111);
    expect_frame(257, 32, 16'hAAAA, 4'b1111);
    expect_at(192, K_PEND, 4'h0);
    expect_at(224, K_PEND, 4'h1);
    expect_at(225, K_PEND, 4'h1);
    expect_at(256, K_PEND, 4'h0);
    load(170, 16'h1111);
    load(180, 16'hAAAA);
    load(200, 16'hAAAA);
    load(224, 16'h5555);

    // Scenario 5: asynchronous reset mid-slot with a value shown and one pending.
    expect_frame(289, 12, 16'hEDCB, 4'b1111);
    expect_at(300, K_PEND, 4'h1);
    load(270, 16'h1234);
    load(300, 16'h9999);
    goto(303);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drained actual=%0d required=0", sb.size());
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_now("async_dig_n", DIG_N, 4'hF);
    check_now("async_in", {IN_8, IN_4, IN_2, IN_1}, 4'hF);
    check_now("async_pending", {3'b0, PENDING}, 4'h0);
    check_now("async_frame", {3'b0, FRAME}, 4'h0);
    // LOAD during reset must be ignored; the repeated cadence must show a blank display.
    LOAD  = 1'b1;
    VALUE = 16'h7777;
    expect_frame(1, 32, 16'hFFFF, 4'b1111);
    expect_at(1, K_PEND, 4'h0);
    expect_at(33, K_PEND, 4'h0);
    expect_at(1, K_FRM, 4'h0);
    expect_at(32, K_FRM, 4'h0);
    expect_at(33, K_FRM, 4'h1);
    expect_at(34, K_FRM, 4'h0);
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    goto(35);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
